// File: rtl/pc_fetch_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_gen_pkg
// Brief    : Shared definitions for the PC generator: branch funct3 codes,
//            ALU compare codes, default datapath width and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_gen_pkg;

  localparam int DEF_MXLEN = 32;

  // Conditional branch funct3 encodings (010/011 are unused by the ISA)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU compare outcome for the resolving branch
  localparam logic [1:0] ALU_BR_EQ = 2'd0;
  localparam logic [1:0] ALU_BR_LT = 2'd1;
  localparam logic [1:0] ALU_BR_GT = 2'd2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_HALT = 2'd3
  } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_gen_if
// Brief    : Fetch request bus between the PC generator (master) and the
//            instruction fetch unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_gen_if #(
  parameter int MXLEN = 32
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [MXLEN-1:0] fetch_pc;
  logic             fetch_stale;

  modport master (
    output fetch_valid,
    output fetch_pc,
    output fetch_stale,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    input  fetch_stale,
    output fetch_ready
  );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_sel
// Brief    : Combinational redirect resolution: branch taken decode, source
//            priority, target computation and alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_sel
  import pc_fetch_gen_pkg::*;
#(
  parameter int MXLEN  = DEF_MXLEN,
  parameter int IALIGN = 4
) (
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  input  logic [1:0]       br_eval,
  input  logic             jal_valid,
  input  logic             jalr_valid,
  input  logic [MXLEN-1:0] instr_pc,
  input  logic [MXLEN-1:0] imm,
  input  logic [MXLEN-1:0] jalr_base,
  input  logic             trap_req,
  input  logic [MXLEN-1:0] trap_vec,
  input  logic             mret_req,
  input  logic [MXLEN-1:0] mepc,
  output logic             redir,
  output logic [MXLEN-1:0] target,
  output logic             misalign,
  output logic             illegal
);

  localparam logic [MXLEN-1:0] c_align_mask = MXLEN'(IALIGN - 1);
  localparam logic [MXLEN-1:0] c_lsb_clear  = {{(MXLEN-1){1'b1}}, 1'b0};

  logic w_taken;
  logic w_bad_f3;
  logic w_cand;
  logic w_chk;
  logic w_higher;

  // Decode whether the resolving conditional branch is taken
  always_comb begin
    w_taken  = 1'b0;
    w_bad_f3 = 1'b0;
    case (br_funct3)
      F3_BEQ:           w_taken = (br_eval == ALU_BR_EQ);
      F3_BNE:           w_taken = (br_eval != ALU_BR_EQ);
      F3_BLT, F3_BLTU:  w_taken = (br_eval == ALU_BR_LT);
      F3_BGE, F3_BGEU:  w_taken = (br_eval == ALU_BR_GT) || (br_eval == ALU_BR_EQ);
      default:          w_bad_f3 = 1'b1;
    endcase
  end

  // Pick the highest-priority source and its target; only PC-relative and
  // register-based jumps are alignment checked
  always_comb begin
    w_cand = 1'b0;
    w_chk  = 1'b0;
    target = '0;
    if (trap_req) begin
      w_cand = 1'b1;
      target = trap_vec;
    end else if (mret_req) begin
      w_cand = 1'b1;
      target = mepc;
    end else if (jalr_valid) begin
      w_cand = 1'b1;
      w_chk  = 1'b1;
      target = (jalr_base + imm) & c_lsb_clear;
    end else if (jal_valid) begin
      w_cand = 1'b1;
      w_chk  = 1'b1;
      target = instr_pc + imm;
    end else if (br_valid && w_taken) begin
      w_cand = 1'b1;
      w_chk  = 1'b1;
      target = instr_pc + imm;
    end
    w_higher = trap_req || mret_req || jalr_valid || jal_valid;
    misalign = w_chk && ((target & c_align_mask) != '0);
    redir    = w_cand && !misalign;
    illegal  = br_valid && w_bad_f3 && !w_higher;
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_gen
// Brief    : PC generator driving the fetch request handshake; applies
//            prioritised redirects, holding them while a request is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int               MXLEN   = DEF_MXLEN,
  parameter logic [MXLEN-1:0] RST_VEC = '0,
  parameter int               IALIGN  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  pc_fetch_gen_if.master   fetch_bus,
  input  logic             halt,
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  input  logic [1:0]       br_eval,
  input  logic             jal_valid,
  input  logic             jalr_valid,
  input  logic [MXLEN-1:0] instr_pc,
  input  logic [MXLEN-1:0] imm,
  input  logic [MXLEN-1:0] jalr_base,
  input  logic             trap_req,
  input  logic [MXLEN-1:0] trap_vec,
  input  logic             mret_req,
  input  logic [MXLEN-1:0] mepc,
  output logic             misalign_exc,
  output logic [MXLEN-1:0] misalign_addr,
  output logic             illegal_br
);

  pc_state_e        r_state, w_state_nxt;
  logic [MXLEN-1:0] r_pc, w_pc_nxt;
  logic [MXLEN-1:0] r_pend_pc, w_pend_nxt;
  logic             r_hold;     // last cycle's request was not accepted
  logic             w_valid, w_stale, w_stalled, w_accept;
  logic             w_redir, w_misalign, w_illegal;
  logic [MXLEN-1:0] w_target;

  pc_redirect_sel #(
    .MXLEN  (MXLEN),
    .IALIGN (IALIGN)
  ) u_sel (
    .br_valid   (br_valid),
    .br_funct3  (br_funct3),
    .br_eval    (br_eval),
    .jal_valid  (jal_valid),
    .jalr_valid (jalr_valid),
    .instr_pc   (instr_pc),
    .imm        (imm),
    .jalr_base  (jalr_base),
    .trap_req   (trap_req),
    .trap_vec   (trap_vec),
    .mret_req   (mret_req),
    .mepc       (mepc),
    .redir      (w_redir),
    .target     (w_target),
    .misalign   (w_misalign),
    .illegal    (w_illegal)
  );

  assign fetch_bus.fetch_valid = w_valid;
  assign fetch_bus.fetch_pc    = r_pc;
  assign fetch_bus.fetch_stale = w_stale;

  // State, PC, pending target and stall-hold registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_BOOT;
      r_pc      <= RST_VEC;
      r_pend_pc <= '0;
      r_hold    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_hold    <= w_stalled;
    end
  end

  // One-cycle exception pulses; the offending address stays visible
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
      illegal_br    <= 1'b0;
    end else begin
      misalign_exc <= w_misalign;
      illegal_br   <= w_illegal;
      if (w_misalign) begin
        misalign_addr <= w_target;
      end
    end
  end

  // Request outputs, redirect handling and next-state selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_pc;
    w_valid     = 1'b0;
    w_stale     = 1'b0;
    case (r_state)
      ST_RUN:  w_valid = !halt || r_hold;   // halt waits for the handshake
      ST_PEND: begin
        w_valid = 1'b1;
        w_stale = 1'b1;
      end
      default: w_valid = 1'b0;
    endcase
    w_stalled = w_valid && !fetch_bus.fetch_ready;
    w_accept  = w_valid && fetch_bus.fetch_ready;
    if (w_redir && w_valid) begin
      w_stale = 1'b1;
    end

    if (w_redir) begin
      if (w_stalled) begin
        w_pend_nxt  = w_target;
        w_state_nxt = ST_PEND;
      end else begin
        w_pc_nxt    = w_target;
        w_state_nxt = halt ? ST_HALT : ST_RUN;
      end
    end else if (r_state == ST_PEND) begin
      if (w_accept) begin
        w_pc_nxt    = r_pend_pc;
        w_state_nxt = halt ? ST_HALT : ST_RUN;
      end
    end else begin
      if (w_accept) begin
        w_pc_nxt = r_pc + MXLEN'(4);
      end
      if (!w_stalled) begin
        w_state_nxt = halt ? ST_HALT : ST_RUN;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_gen
// Brief    : Directed self-checking bench for pc_fetch_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_gen;
  import pc_fetch_gen_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt;
  logic        br_valid, jal_valid, jalr_valid, trap_req, mret_req;
  logic [2:0]  br_funct3;
  logic [1:0]  br_eval;
  logic [31:0] instr_pc, imm, jalr_base, trap_vec, mepc;
  logic        misalign_exc, illegal_br;
  logic [31:0] misalign_addr;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 CLK = ~CLK;

  pc_fetch_gen_if #(.MXLEN(32)) fbus ();

  pc_fetch_gen #(
    .MXLEN   (32),
    .RST_VEC (32'h0000_0000),
    .IALIGN  (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .fetch_bus     (fbus),
    .halt          (halt),
    .br_valid      (br_valid),
    .br_funct3     (br_funct3),
    .br_eval       (br_eval),
    .jal_valid     (jal_valid),
    .jalr_valid    (jalr_valid),
    .instr_pc      (instr_pc),
    .imm           (imm),
    .jalr_base     (jalr_base),
    .trap_req      (trap_req),
    .trap_vec      (trap_vec),
    .mret_req      (mret_req),
    .mepc          (mepc),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr),
    .illegal_br    (illegal_br)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic v, input logic [31:0] pc, input logic st);
    check_val({tag, ".valid"}, 32'(fbus.fetch_valid), 32'(v));
    check_val({tag, ".pc"},    fbus.fetch_pc,         pc);
    check_val({tag, ".stale"}, 32'(fbus.fetch_stale), 32'(st));
  endtask

  task automatic clr_in();
    br_valid   = 1'b0;
    br_funct3  = F3_BEQ;
    br_eval    = ALU_BR_EQ;
    jal_valid  = 1'b0;
    jalr_valid = 1'b0;
    trap_req   = 1'b0;
    mret_req   = 1'b0;
    instr_pc   = '0;
    imm        = '0;
    jalr_base  = '0;
    trap_vec   = '0;
    mepc       = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // apply whatever inputs are set for exactly one edge, then clear them
  task automatic pulse();
    @(posedge CLK);
    #1;
    clr_in();
    #1;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [1:0] ev,
                        input logic [31:0] ipc, input logic [31:0] im);
    br_valid  = 1'b1;
    br_funct3 = f3;
    br_eval   = ev;
    instr_pc  = ipc;
    imm       = im;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    halt = 1'b0;
    clr_in();
    fbus.fetch_ready = 1'b1;
    tick();
    tick();

    // reset state
    chk_fetch("reset", 1'b0, 32'h0, 1'b0);
    check_val("reset.misalign_exc",  32'(misalign_exc), 32'h0);
    check_val("reset.misalign_addr", misalign_addr,     32'h0);
    check_val("reset.illegal_br",    32'(illegal_br),   32'h0);

    // boot bubble then sequential fetch
    RST = 1'b0;
    #1;
    check_val("boot.valid", 32'(fbus.fetch_valid), 32'h0);
    tick(); chk_fetch("seq0", 1'b1, 32'h0, 1'b0);
    tick(); chk_fetch("seq4", 1'b1, 32'h4, 1'b0);
    tick(); chk_fetch("seq8", 1'b1, 32'h8, 1'b0);

    // JAL to the top of the address space, then wrap to 0
    jal_valid = 1'b1; instr_pc = 32'hFFFF_FFF0; imm = 32'h0000_000C;
    #1;
    check_val("jal_top.stale_now", 32'(fbus.fetch_stale), 32'h1);
    pulse(); chk_fetch("jal_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();  chk_fetch("wrap",    1'b1, 32'h0,         1'b0);

    // branch decode
    set_br(F3_BNE, ALU_BR_LT, 32'h100, 32'hFFFF_FFF8);
    pulse(); chk_fetch("bne_taken", 1'b1, 32'hF8, 1'b0);
    set_br(F3_BEQ, ALU_BR_GT, 32'h200, 32'h40);
    pulse(); chk_fetch("beq_not_taken", 1'b1, 32'hFC, 1'b0);
    set_br(F3_BGEU, ALU_BR_EQ, 32'h300, 32'h10);
    pulse(); chk_fetch("bgeu_eq_taken", 1'b1, 32'h310, 1'b0);
    set_br(F3_BLT, ALU_BR_GT, 32'h600, 32'h10);
    pulse(); chk_fetch("blt_not_taken", 1'b1, 32'h314, 1'b0);
    set_br(3'b010, ALU_BR_EQ, 32'h400, 32'h0);
    pulse(); chk_fetch("illegal_f3", 1'b1, 32'h318, 1'b0);
    check_val("illegal_f3.pulse", 32'(illegal_br), 32'h1);
    tick();
    check_val("illegal_f3.clear", 32'(illegal_br), 32'h0);
    check_val("illegal_f3.seq",   fbus.fetch_pc,   32'h31C);

    // redirect during a stalled request
    jal_valid = 1'b1; instr_pc = 32'h0; imm = 32'h20;
    pulse(); chk_fetch("to_0x20", 1'b1, 32'h20, 1'b0);
    fbus.fetch_ready = 1'b0;
    jal_valid = 1'b1; instr_pc = 32'h10; imm = 32'h40;
    #1;
    check_val("stall_jal.stale_now", 32'(fbus.fetch_stale), 32'h1);
    pulse(); chk_fetch("pend1", 1'b1, 32'h20, 1'b1);
    tick();  chk_fetch("pend2", 1'b1, 32'h20, 1'b1);
    fbus.fetch_ready = 1'b1;
    tick();  chk_fetch("pend_done", 1'b1, 32'h50, 1'b0);

    // priority: trap > mret > jalr > jal > branch
    trap_req = 1'b1; trap_vec = 32'h80; mret_req = 1'b1; mepc = 32'h90;
    set_br(F3_BEQ, ALU_BR_EQ, 32'h100, 32'h20);
    pulse(); chk_fetch("prio_trap", 1'b1, 32'h80, 1'b0);
    mret_req = 1'b1; mepc = 32'h90; jalr_valid = 1'b1; jalr_base = 32'h200;
    jal_valid = 1'b1; imm = 32'h700;
    pulse(); chk_fetch("prio_mret", 1'b1, 32'h90, 1'b0);

    // JALR LSB clearing and misalignment
    jalr_valid = 1'b1; jalr_base = 32'h101; imm = 32'h0;
    pulse(); chk_fetch("jalr_lsb", 1'b1, 32'h100, 1'b0);
    check_val("jalr_lsb.no_exc", 32'(misalign_exc), 32'h0);
    jalr_valid = 1'b1; jalr_base = 32'h103; imm = 32'h0;
    pulse(); chk_fetch("jalr_mis", 1'b1, 32'h104, 1'b0);
    check_val("jalr_mis.exc",  32'(misalign_exc), 32'h1);
    check_val("jalr_mis.addr", misalign_addr,     32'h102);
    tick();
    check_val("jalr_mis.exc_clear", 32'(misalign_exc), 32'h0);
    check_val("jalr_mis.addr_held", misalign_addr,     32'h102);
    check_val("jalr_mis.seq",       fbus.fetch_pc,     32'h108);
    jal_valid = 1'b1; instr_pc = 32'h200; imm = 32'h2;
    pulse(); chk_fetch("jal_mis", 1'b1, 32'h10C, 1'b0);
    check_val("jal_mis.exc",  32'(misalign_exc), 32'h1);
    check_val("jal_mis.addr", misalign_addr,     32'h202);

    // halt during a stall is deferred until the handshake
    tick(); chk_fetch("pre_halt", 1'b1, 32'h110, 1'b0);
    fbus.fetch_ready = 1'b0;
    tick(); chk_fetch("halt_stall", 1'b1, 32'h110, 1'b0);
    halt = 1'b1;
    #1;
    check_val("halt_deferred.valid", 32'(fbus.fetch_valid), 32'h1);
    tick(); chk_fetch("halt_held", 1'b1, 32'h110, 1'b0);
    fbus.fetch_ready = 1'b1;
    tick(); chk_fetch("halted",        1'b0, 32'h114, 1'b0);
    tick(); chk_fetch("halted_frozen", 1'b0, 32'h114, 1'b0);
    halt = 1'b0;
    tick(); chk_fetch("resume",  1'b1, 32'h114, 1'b0);
    tick(); chk_fetch("resume4", 1'b1, 32'h118, 1'b0);

    // asynchronous reset while a redirect is pending
    fbus.fetch_ready = 1'b0;
    jal_valid = 1'b1; instr_pc = 32'h0; imm = 32'h500;
    pulse(); chk_fetch("pend_rst", 1'b1, 32'h118, 1'b1);
    RST = 1'b1;
    #1;
    chk_fetch("rst_in_pend", 1'b0, 32'h0, 1'b0);
    tick();
    fbus.fetch_ready = 1'b1;
    RST = 1'b0;
    #1;
    check_val("rst_boot.valid", 32'(fbus.fetch_valid), 32'h0);
    tick(); chk_fetch("post_rst0", 1'b1, 32'h0, 1'b0);
    tick(); chk_fetch("post_rst4", 1'b1, 32'h4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
